// File: rtl/ahb_arbiter_slave_2_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | AHB_package : HTRANS codes, HBURST/arbiter enums, burst_len()      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package AHB_package;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef enum logic [2:0] {
    BURST_SINGLE = 3'b000,
    BURST_INCR   = 3'b001,
    BURST_WRAP4  = 3'b010,
    BURST_INCR4  = 3'b011,
    BURST_WRAP8  = 3'b100,
    BURST_INCR8  = 3'b101,
    BURST_WRAP16 = 3'b110,
    BURST_INCR16 = 3'b111
  } hburst_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'b00,
    ARB_OWN   = 2'b01,
    ARB_BURST = 2'b10
  } arb_state_t;

  // Beats in a fixed-length burst; SINGLE and INCR report 1.
  function automatic logic [4:0] burst_len(input hburst_t b);
    case (b)
      BURST_WRAP4,  BURST_INCR4:  return 5'd4;
      BURST_WRAP8,  BURST_INCR8:  return 5'd8;
      BURST_WRAP16, BURST_INCR16: return 5'd16;
      default:                    return 5'd1;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_arbiter_slave_2_rr_picker.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ahb_rr_picker : first requester above ptr (wrapping), one-hot      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module ahb_rr_picker #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] grant_o,
  output logic [W-1:0] idx_o,
  output logic         valid_o
);

  int cand;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = 0;
    // i = N wraps back to ptr itself, so the current owner is searched last
    for (int i = 1; i <= N; i++) begin
      cand = (int'(ptr_i) + i) % N;
      if (!valid_o && req_i[cand]) begin
        grant_o[cand] = 1'b1;
        idx_o         = W'(cand);
        valid_o       = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ahb_arbiter_slave_2.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ahb_arbiter_slave_2 : round-robin AHB arbiter with burst locking   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module ahb_arbiter_slave_2
  import AHB_package::*;
#(
  parameter int CHANNEL_NUM = 2,
  parameter int MASTER_W    = $clog2(CHANNEL_NUM)
) (
  input  logic                        hclk,
  input  logic                        hresetn,
  input  logic [CHANNEL_NUM-1:0]      hreq,
  input  logic [CHANNEL_NUM-1:0][1:0] htrans,
  input  logic [CHANNEL_NUM-1:0][2:0] hburst,
  input  logic                        hready,
  output logic [CHANNEL_NUM-1:0]      addr_sel,
  output logic [CHANNEL_NUM-1:0]      data_sel,
  output logic [MASTER_W-1:0]         hmaster
);

  arb_state_t             state_q, state_d;
  logic [MASTER_W-1:0]    ptr_q, ptr_d;
  logic [MASTER_W-1:0]    hmaster_q, hmaster_d;
  logic [CHANNEL_NUM-1:0] addr_sel_q, addr_sel_d;
  logic [CHANNEL_NUM-1:0] data_sel_q, data_sel_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   park_q, park_d;

  logic [CHANNEL_NUM-1:0] win_grant;
  logic [MASTER_W-1:0]    win_idx;
  logic                   win_valid;
  logic                   arb;
  logic [1:0]             own_trans;
  logic [2:0]             own_burst;

  assign own_trans = htrans[hmaster_q];
  assign own_burst = hburst[hmaster_q];

  ahb_rr_picker #(
    .N (CHANNEL_NUM),
    .W (MASTER_W)
  ) u_picker (
    .req_i   (hreq),
    .ptr_i   (ptr_q),
    .grant_o (win_grant),
    .idx_o   (win_idx),
    .valid_o (win_valid)
  );

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q    <= ARB_IDLE;
      ptr_q      <= '0;
      hmaster_q  <= '0;
      addr_sel_q <= '0;
      data_sel_q <= '0;
      cnt_q      <= '0;
      park_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hmaster_q  <= hmaster_d;
      addr_sel_q <= addr_sel_d;
      data_sel_q <= data_sel_d;
      cnt_q      <= cnt_d;
      park_q     <= park_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    hmaster_d  = hmaster_q;
    addr_sel_d = addr_sel_q;
    data_sel_d = data_sel_q;
    cnt_d      = cnt_q;
    park_d     = park_q;
    arb        = 1'b0;
    if (hready) begin
      data_sel_d = addr_sel_q;
      case (state_q)
        ARB_IDLE: arb = 1'b1;
        ARB_OWN: begin
          if (own_trans == HTRANS_NONSEQ && own_burst != BURST_SINGLE) begin
            state_d = ARB_BURST;
            park_d  = 1'b0;
            // A zero count while locked marks an undefined-length INCR burst
            cnt_d   = (own_burst == BURST_INCR) ? 4'd0
                    : 4'(burst_len(hburst_t'(own_burst)) - 5'd1);
          end else begin
            arb = 1'b1;
          end
        end
        ARB_BURST: begin
          case (own_trans)
            HTRANS_SEQ: begin
              if (cnt_q == 4'd1) begin
                cnt_d = 4'd0;
                arb   = 1'b1;
              end else if (cnt_q != 4'd0) begin
                cnt_d = cnt_q - 4'd1;
              end
            end
            HTRANS_BUSY: cnt_d = cnt_q;
            default: begin
              cnt_d = 4'd0;
              arb   = 1'b1;
            end
          endcase
        end
        default: state_d = ARB_IDLE;
      endcase

      if (arb) begin
        if (win_valid) begin
          addr_sel_d = win_grant;
          hmaster_d  = win_idx;
          ptr_d      = win_idx;
          state_d    = ARB_OWN;
          park_d     = 1'b0;
        end else if (state_q == ARB_OWN && !park_q) begin
          // First empty accepted cycle: keep parked on the owner
          park_d = 1'b1;
        end else begin
          addr_sel_d = '0;
          hmaster_d  = '0;
          state_d    = ARB_IDLE;
          park_d     = 1'b0;
        end
      end
    end
  end

  always_comb begin
    addr_sel = addr_sel_q;
    data_sel = data_sel_q;
    hmaster  = hmaster_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_ahb_arbiter_slave_2.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_ahb_arbiter_slave_2 : scoreboard bench for ahb_arbiter_slave_2  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_ahb_arbiter_slave_2;

  localparam logic [1:0] ID  = 2'b00;
  localparam logic [1:0] BS  = 2'b01;
  localparam logic [1:0] NS  = 2'b10;
  localparam logic [1:0] SQ  = 2'b11;
  localparam logic [2:0] SGL = 3'b000;
  localparam logic [2:0] INC = 3'b001;
  localparam logic [2:0] I4  = 3'b011;
  localparam logic [2:0] I8  = 3'b101;

  logic            hclk = 1'b0;
  logic            hresetn = 1'b0;
  logic [1:0]      hreq = '0;
  logic [1:0][1:0] htrans = '0;
  logic [1:0][2:0] hburst = '0;
  logic            hready = 1'b1;
  logic [1:0]      addr_sel;
  logic [1:0]      data_sel;
  logic [0:0]      hmaster;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [1:0] req;
    logic [1:0] t0;
    logic [2:0] b0;
    logic [1:0] t1;
    logic [2:0] b1;
    logic       rdy;
    logic [4:0] exp;  // {addr_sel, data_sel, hmaster} after the edge
  } row_t;

  row_t       plan[$];
  logic [4:0] sb[$];
  logic [4:0] obs;
  logic [4:0] exp;

  always #5 hclk = ~hclk;

  ahb_arbiter_slave_2 #(
    .CHANNEL_NUM (2),
    .MASTER_W    (1)
  ) dut (
    .hclk     (hclk),
    .hresetn  (hresetn),
    .hreq     (hreq),
    .htrans   (htrans),
    .hburst   (hburst),
    .hready   (hready),
    .addr_sel (addr_sel),
    .data_sel (data_sel),
    .hmaster  (hmaster)
  );

  function automatic void add(input logic [1:0] req, input logic [1:0] t0, input logic [2:0] b0,
                              input logic [1:0] t1, input logic [2:0] b1, input logic rdy,
                              input logic [1:0] ea, input logic [1:0] ed, input logic eh);
    row_t r;
    r.req = req; r.t0 = t0; r.b0 = b0; r.t1 = t1; r.b1 = b1; r.rdy = rdy;
    r.exp = {ea, ed, eh};
    plan.push_back(r);
  endfunction

  // Drives one cycle of stimulus and queues the outputs it should produce.
  task automatic drive_row(input row_t r);
    hreq      = r.req;
    htrans[0] = r.t0;
    hburst[0] = r.b0;
    htrans[1] = r.t1;
    hburst[1] = r.b1;
    hready    = r.rdy;
    sb.push_back(r.exp);
    @(posedge hclk);
    #1;
  endtask

  task automatic apply_reset();
    hresetn = 1'b0;
    hreq    = '0;
    htrans  = '0;
    hburst  = '0;
    hready  = 1'b1;
    repeat (2) @(posedge hclk);
    #1;
    hresetn = 1'b1;
    plan.delete();
    sb.delete();
  endtask

  task automatic test_reset();
    hresetn = 1'b0;
    hreq    = 2'b11;
    htrans  = {NS, NS};
    repeat (2) @(posedge hclk);
    #1;
    obs = {addr_sel, data_sel, hmaster};
    checks++;
    if (obs !== 5'b0) begin
      failures++;
      $display("FAIL reset_values: got %b required %b", obs, 5'b0);
    end
    apply_reset();
  endtask

  task automatic test_single();
    apply_reset();
    add(2'b01, NS, SGL, ID, SGL, 1'b1, 2'b01, 2'b00, 1'b0);
    add(2'b01, NS, SGL, ID, SGL, 1'b1, 2'b01, 2'b01, 1'b0);
    add(2'b00, ID, SGL, ID, SGL, 1'b1, 2'b01, 2'b01, 1'b0);  // parked
    add(2'b00, ID, SGL, ID, SGL, 1'b1, 2'b00, 2'b01, 1'b0);  // second empty cycle
    add(2'b00, ID, SGL, ID, SGL, 1'b1, 2'b00, 2'b00, 1'b0);
    for (int i = 0; i < plan.size(); i++) begin
      drive_row(plan[i]);
      exp = sb.pop_front();
      obs = {addr_sel, data_sel, hmaster};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL single step%0d: got %b required %b", i, obs, exp);
      end
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    add(2'b01, NS, SGL, NS, SGL, 1'b1, 2'b01, 2'b00, 1'b0);
    add(2'b11, NS, SGL, NS, SGL, 1'b1, 2'b10, 2'b01, 1'b1);
    add(2'b11, NS, SGL, NS, SGL, 1'b1, 2'b01, 2'b10, 1'b0);
    add(2'b11, NS, SGL, NS, SGL, 1'b1, 2'b10, 2'b01, 1'b1);
    add(2'b11, NS, SGL, NS, SGL, 1'b1, 2'b01, 2'b10, 1'b0);
    for (int i = 0; i < plan.size(); i++) begin
      drive_row(plan[i]);
      exp = sb.pop_front();
      obs = {addr_sel, data_sel, hmaster};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL round_robin step%0d: got %b required %b", i, obs, exp);
      end
    end
  endtask

  task automatic test_incr4_lock();
    apply_reset();
    add(2'b01, NS, I4,  ID, SGL, 1'b1, 2'b01, 2'b00, 1'b0);
    add(2'b11, NS, I4,  NS, SGL, 1'b1, 2'b01, 2'b01, 1'b0);  // beat 1
    add(2'b11, SQ, I4,  NS, SGL, 1'b1, 2'b01, 2'b01, 1'b0);  // beat 2
    add(2'b11, BS, I4,  NS, SGL, 1'b1, 2'b01, 2'b01, 1'b0);  // busy
    add(2'b11, SQ, I4,  NS, SGL, 1'b1, 2'b01, 2'b01, 1'b0);  // beat 3
    add(2'b11, SQ, I4,  NS, SGL, 1'b1, 2'b10, 2'b01, 1'b1);  // beat 4
    add(2'b10, ID, SGL, NS, SGL, 1'b1, 2'b10, 2'b10, 1'b1);
    for (int i = 0; i < plan.size(); i++) begin
      drive_row(plan[i]);
      exp = sb.pop_front();
      obs = {addr_sel, data_sel, hmaster};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL incr4_lock step%0d: got %b required %b", i, obs, exp);
      end
    end
  endtask

  task automatic test_wait_states();
    apply_reset();
    add(2'b01, NS, I4,  ID, SGL, 1'b1, 2'b01, 2'b00, 1'b0);
    add(2'b11, NS, I4,  NS, SGL, 1'b0, 2'b01, 2'b00, 1'b0);
    add(2'b11, NS, I4,  NS, SGL, 1'b0, 2'b01, 2'b00, 1'b0);
    add(2'b11, NS, I4,  NS, SGL, 1'b0, 2'b01, 2'b00, 1'b0);
    add(2'b11, NS, I4,  NS, SGL, 1'b1, 2'b01, 2'b01, 1'b0);  // beat 1
    add(2'b11, SQ, I4,  NS, SGL, 1'b1, 2'b01, 2'b01, 1'b0);  // beat 2
    add(2'b11, SQ, I4,  NS, SGL, 1'b0, 2'b01, 2'b01, 1'b0);
    add(2'b11, SQ, I4,  NS, SGL, 1'b0, 2'b01, 2'b01, 1'b0);
    add(2'b11, SQ, I4,  NS, SGL, 1'b0, 2'b01, 2'b01, 1'b0);
    add(2'b11, SQ, I4,  NS, SGL, 1'b1, 2'b01, 2'b01, 1'b0);  // beat 3
    add(2'b11, SQ, I4,  NS, SGL, 1'b1, 2'b10, 2'b01, 1'b1);  // beat 4
    add(2'b10, ID, SGL, NS, SGL, 1'b0, 2'b10, 2'b01, 1'b1);  // data_sel lag stretched
    add(2'b10, ID, SGL, NS, SGL, 1'b1, 2'b10, 2'b10, 1'b1);
    for (int i = 0; i < plan.size(); i++) begin
      drive_row(plan[i]);
      exp = sb.pop_front();
      obs = {addr_sel, data_sel, hmaster};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL wait_states step%0d: got %b required %b", i, obs, exp);
      end
    end
  endtask

  task automatic test_incr_undefined();
    apply_reset();
    add(2'b01, NS, INC, ID, SGL, 1'b1, 2'b01, 2'b00, 1'b0);
    add(2'b11, NS, INC, NS, SGL, 1'b1, 2'b01, 2'b01, 1'b0);
    add(2'b11, SQ, INC, NS, SGL, 1'b1, 2'b01, 2'b01, 1'b0);
    add(2'b11, SQ, INC, NS, SGL, 1'b1, 2'b01, 2'b01, 1'b0);
    add(2'b10, SQ, INC, NS, SGL, 1'b1, 2'b01, 2'b01, 1'b0);  // hreq drop ignored
    add(2'b10, SQ, INC, NS, SGL, 1'b1, 2'b01, 2'b01, 1'b0);
    add(2'b11, SQ, INC, NS, SGL, 1'b1, 2'b01, 2'b01, 1'b0);
    add(2'b11, SQ, INC, NS, SGL, 1'b1, 2'b01, 2'b01, 1'b0);
    add(2'b11, ID, INC, NS, SGL, 1'b1, 2'b10, 2'b01, 1'b1);  // IDLE releases lock
    add(2'b10, ID, SGL, NS, SGL, 1'b1, 2'b10, 2'b10, 1'b1);
    for (int i = 0; i < plan.size(); i++) begin
      drive_row(plan[i]);
      exp = sb.pop_front();
      obs = {addr_sel, data_sel, hmaster};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL incr_undef step%0d: got %b required %b", i, obs, exp);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    add(2'b10, ID, SGL, NS, I8, 1'b1, 2'b10, 2'b00, 1'b1);
    add(2'b10, ID, SGL, NS, I8, 1'b1, 2'b10, 2'b10, 1'b1);  // beat 1
    add(2'b10, ID, SGL, SQ, I8, 1'b1, 2'b10, 2'b10, 1'b1);  // beat 2
    for (int i = 0; i < plan.size(); i++) begin
      drive_row(plan[i]);
      exp = sb.pop_front();
      obs = {addr_sel, data_sel, hmaster};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL reset_mid step%0d: got %b required %b", i, obs, exp);
      end
    end
    #2;
    hresetn = 1'b0;
    #1;
    obs = {addr_sel, data_sel, hmaster};
    checks++;
    if (obs !== 5'b0) begin
      failures++;
      $display("FAIL reset_mid_async: got %b required %b", obs, 5'b0);
    end
    @(posedge hclk);
    #1;
    hresetn = 1'b1;
    // Pointer back at 0: with both requesting, master1 wins first
    plan.delete();
    add(2'b11, NS, SGL, NS, SGL, 1'b1, 2'b10, 2'b00, 1'b1);
    add(2'b11, NS, SGL, NS, SGL, 1'b1, 2'b01, 2'b10, 1'b0);
    for (int i = 0; i < plan.size(); i++) begin
      drive_row(plan[i]);
      exp = sb.pop_front();
      obs = {addr_sel, data_sel, hmaster};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL reset_rearb step%0d: got %b required %b", i, obs, exp);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_incr4_lock();
    test_wait_states();
    test_incr_undefined();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ahb_arbiter_slave_2.md
# ahb_arbiter_slave_2

Round-robin AHB arbiter for slave_2: it chooses which master channel owns slave_2's address phase. Its one-hot grants drive the select inputs of the slave_2 payload muxes: `addr_sel` for the address/control mux and `data_sel` for the write-data mux. A grant is held for the full length of fixed-length bursts and for the full length of undefined-length INCR bursts. A grant changes only on an accepted transfer (`hready`=1).

## Interface
- `CHANNEL_NUM`, 2: number of master channels competing for slave_2 (≥2).
- `MASTER_W`, `$clog2(CHANNEL_NUM)`: width of the owner index.

Ports:
- `hclk`  in  1  clock; single clock domain.
- `hresetn`  in  1  reset; asynchronous, active-low.
- `hreq`  in  `CHANNEL_NUM`  per-master request for slave_2 (decoded address hit).
- `htrans`  in  `[CHANNEL_NUM][2]`  per-master HTRANS.
- `hburst`  in  `[CHANNEL_NUM][3]`  per-master HBURST.
- `hready`  in  1  slave_2 HREADYOUT; high means the current address phase is accepted.
- `addr_sel`  out  `CHANNEL_NUM`  one-hot address-phase owner, or `'0` when nothing is granted.
- `data_sel`  out  `CHANNEL_NUM`  one-hot data-phase owner; this is `addr_sel` delayed by one accepted transfer.
- `hmaster`  out  `MASTER_W`  binary index of the `addr_sel` owner; 0 when `addr_sel`=`'0`.

## Operation
- Reset values: `addr_sel`=`'0`, `data_sel`=`'0`, `hmaster`=0, state=`ARB_IDLE`, round-robin pointer=0, beat counter=0.
- FSM states:
  - `ARB_IDLE`: no owner.
  - `ARB_OWN`: an owner holds the grant, and no burst lock is active.
  - `ARB_BURST`: an owner is locked inside a burst.
- Arbitration point: any cycle with `hready`=1 while in `ARB_IDLE` or `ARB_OWN`, or the last-beat condition in `ARB_BURST`.
  - The winner is the first requester found searching upward from pointer+1 (modulo `CHANNEL_NUM`).
  - The pointer is then set to the winner.
  - The current owner is included in the search. If it keeps `hreq` asserted while others request, it loses to any requester between it and itself in round-robin order.
- No requests at an arbitration point:
  - From `ARB_OWN`: park by keeping `addr_sel`.
  - From `ARB_IDLE`: stay in `ARB_IDLE` with `addr_sel`=`'0`.
  - `ARB_OWN` goes to `ARB_IDLE` only when the owner's `hreq`=0 and no other master requests for 2 consecutive accepted cycles.
- Burst lock: when the owner's NONSEQ is accepted (`hready`=1), the lock depends on `hburst`.
  - SINGLE: no lock; arbitration proceeds normally.
  - INCR4/WRAP4, INCR8/WRAP8, INCR16/WRAP16: load the counter with length−1 (3, 7 or 15) and enter `ARB_BURST`.
  - INCR (undefined length): enter `ARB_BURST` with the counter unused.
- Fixed bursts in `ARB_BURST`:
  - An accepted SEQ decrements the counter.
  - BUSY, or `hready`=0, holds the counter.
  - An accepted SEQ with counter=1 is the last beat: arbitrate, and leave to `ARB_OWN` (any winner) or to `ARB_IDLE`.
- INCR bursts: stay locked while the owner's `htrans` ∈ {SEQ, BUSY}. An accepted IDLE or NONSEQ from the owner releases the lock and counts as an arbitration point.
- Early termination: if the owner drives IDLE or NONSEQ mid fixed burst, clear the counter and treat the cycle as an arbitration point.
- `hreq` dropping mid-burst is ignored; the lock follows `htrans`/`hburst` only.
- `data_sel` is loaded from `addr_sel` on every `hready`=1 cycle and held otherwise.
- Asynchronous reset mid-burst returns every register to its reset value immediately.

## Timing
- Grant latency: a request seen at an accepted edge n drives `addr_sel` from cycle n+1. All outputs are registered.
- `hready`=0 freezes `addr_sel`, `data_sel`, the counter, the pointer and the state.
- `data_sel` lags `addr_sel` by exactly one accepted transfer, so wait states stretch the gap.
- Simultaneous events: a last-beat SEQ and new requests in the same cycle give a new owner in the next cycle, with no idle gap.
- `addr_sel` is never multi-hot.

## Structure
- Shared package `AHB_package` gets:
  - the HTRANS constants (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11);
  - the HBURST enum (SINGLE=000, INCR=001, WRAP4=010, INCR4=011, WRAP8=100, INCR8=101, WRAP16=110, INCR16=111);
  - a `burst_len()` function;
  - the `arb_state_t` enum.
- Sub-module `ahb_rr_picker`: combinational; takes requests and the pointer, and returns the one-hot winner plus a valid flag.

## Test plan
- **Single request:** reset; `hreq`=01, `htrans[0]`=NONSEQ SINGLE, `hready`=1 → `addr_sel`=01 and `hmaster`=0 one cycle later, `data_sel`=01 the following cycle.
- **Round-robin:** both masters request continuously with SINGLE transfers, `hready`=1 → `addr_sel` alternates 01,10,01,10.
- **INCR4 lock:** master0 INCR4 with a BUSY after beat 2, master1 requesting → `addr_sel` stays 01 for all 4 accepted beats plus the BUSY cycle, then switches to 10.
- **Wait states:** `hready`=0 for 3 cycles during the master0 burst while master1 requests → `addr_sel`, `data_sel` and the counter stay frozen.
- **INCR undefined burst:** master0 runs 6 SEQ beats then IDLE → lock released only at the IDLE, and master1 is granted the next cycle.
- **Reset mid-burst:** `hresetn` low during beat 2 of an INCR8 → all outputs go to 0 asynchronously, then a fresh request is re-arbitrated from pointer 0.
